// File: rtl/h2bp.sv
// Shared types and constants for the data-memory responder slice.
package h2bp;

  localparam int MEM_WORD_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Index width for an array of the given depth; never narrower than one bit.
  function automatic int addr_bits(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-addressed storage: one synchronous write port, one combinational read port, no reset.
module dmem_array
  import h2bp::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = addr_bits(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [MEM_WORD_W-1:0] wdata,
  input  logic [AW-1:0]         raddr,
  output logic [MEM_WORD_W-1:0] rdata
);

  logic [MEM_WORD_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding memory responder: accepts a request, waits LATENCY cycles,
// then commits the access and holds the response until the initiator takes it.
module dmem_responder
  import h2bp::*;
#(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [31:0]           req_addr,
  input  logic [MEM_WORD_W-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [MEM_WORD_W-1:0] rsp_rdata,
  output logic                  rsp_error,
  output logic                  busy
);

  localparam int AW = addr_bits(DEPTH);

  state_e                state;
  logic [3:0]            cnt;
  logic                  ready_en;
  logic [31:0]           cap_addr;
  logic                  cap_write;
  logic [MEM_WORD_W-1:0] cap_wdata;

  logic                  accept;
  logic                  enter_resp;
  logic [31:0]           acc_addr;
  logic                  acc_write;
  logic [MEM_WORD_W-1:0] acc_wdata;
  logic                  in_range;
  logic [MEM_WORD_W-1:0] rd_word;

  assign req_ready  = ready_en && (state == ST_IDLE);
  assign busy       = (state != ST_IDLE);
  assign accept     = req_valid && req_ready;
  assign enter_resp = (accept && (LATENCY == 0)) || ((state == ST_WAIT) && (cnt == 4'd0));

  // With zero latency the commit happens on the acceptance edge itself,
  // before the capture registers hold the request, so use the live inputs.
  assign acc_addr  = (state == ST_IDLE) ? req_addr  : cap_addr;
  assign acc_write = (state == ST_IDLE) ? req_write : cap_write;
  assign acc_wdata = (state == ST_IDLE) ? req_wdata : cap_wdata;
  assign in_range  = (acc_addr < 32'(DEPTH));

  dmem_array #(
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_array (
    .clk  (clk),
    .we   (enter_resp && acc_write && in_range),
    .waddr(acc_addr[AW-1:0]),
    .wdata(acc_wdata),
    .raddr(acc_addr[AW-1:0]),
    .rdata(rd_word)
  );

  // Holds req_ready low until the first edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ready_en <= 1'b0;
    else        ready_en <= 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt       <= 4'd0;
      cap_addr  <= '0;
      cap_write <= 1'b0;
      cap_wdata <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_error <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            cap_addr  <= req_addr;
            cap_write <= req_write;
            cap_wdata <= req_wdata;
            if (LATENCY == 0) begin
              state <= ST_RESP;
            end else begin
              state <= ST_WAIT;
              cnt   <= 4'(LATENCY - 1);
            end
          end
        end
        ST_WAIT: begin
          if (cnt == 4'd0) state <= ST_RESP;
          else             cnt   <= cnt - 4'd1;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            state     <= ST_IDLE;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_error <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase

      if (enter_resp) begin
        rsp_valid <= 1'b1;
        rsp_error <= !in_range;
        rsp_rdata <= (in_range && !acc_write) ? rd_word : '0;
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: a LATENCY=2 instance for most scenarios and a
// LATENCY=0 instance for back-to-back traffic, both checked against a word-level memory model.
module tb_dmem_responder;
  import h2bp::*;

  localparam int DEPTH = 256;
  localparam int LAT_A = 2;
  localparam int LAT_B = 0;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        a_req_valid, a_req_ready, a_req_write, a_rsp_valid, a_rsp_ready, a_rsp_error, a_busy;
  logic [31:0] a_req_addr, a_req_wdata, a_rsp_rdata;
  logic        b_req_valid, b_req_ready, b_req_write, b_rsp_valid, b_rsp_ready, b_rsp_error, b_busy;
  logic [31:0] b_req_addr, b_req_wdata, b_rsp_rdata;

  int errors = 0;
  int checks = 0;
  logic [31:0] model_a [logic [31:0]];
  logic [31:0] model_b [logic [31:0]];

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(LAT_A)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_write(a_req_write),
    .req_addr(a_req_addr), .req_wdata(a_req_wdata),
    .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready), .rsp_rdata(a_rsp_rdata),
    .rsp_error(a_rsp_error), .busy(a_busy)
  );

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(LAT_B)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_write(b_req_write),
    .req_addr(b_req_addr), .req_wdata(b_req_wdata),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_rdata(b_rsp_rdata),
    .rsp_error(b_rsp_error), .busy(b_busy)
  );

  task automatic noise_a();
    a_req_valid = 1'($urandom_range(0, 1));
    a_req_write = 1'($urandom_range(0, 1));
    a_req_addr  = $urandom;
    a_req_wdata = $urandom;
  endtask

  // One transaction on instance A; reports what was observed, judging is left to the caller.
  task automatic run_txn(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                         input int hold, output int lat, output logic [31:0] rdata,
                         output logic err, output bit stable, output bit ready_low,
                         output bit idle_ok, output bit timeout);
    stable = 1; ready_low = 1; idle_ok = 0; timeout = 0; lat = 0; rdata = '0; err = 1'b0;
    a_req_valid = 1'b1; a_req_write = wr; a_req_addr = addr; a_req_wdata = wd; a_rsp_ready = 1'b0;
    @(posedge clk); #1;
    noise_a();
    while (a_rsp_valid !== 1'b1 && lat < 40) begin
      if (a_req_ready !== 1'b0) ready_low = 0;
      @(posedge clk); #1;
      lat++;
      noise_a();
    end
    if (a_rsp_valid !== 1'b1) begin
      timeout = 1;
      a_req_valid = 1'b0;
      return;
    end
    rdata = a_rsp_rdata;
    err   = a_rsp_error;
    if (a_req_ready !== 1'b0) ready_low = 0;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      noise_a();
      if (a_rsp_valid !== 1'b1 || a_rsp_rdata !== rdata || a_rsp_error !== err) stable = 0;
      if (a_req_ready !== 1'b0) ready_low = 0;
    end
    a_req_valid = 1'b0;
    a_rsp_ready = 1'b1;
    @(posedge clk); #1;
    a_rsp_ready = 1'b0;
    idle_ok = (a_busy === 1'b0 && a_req_ready === 1'b1 && a_rsp_valid === 1'b0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    a_req_valid = 0; a_req_write = 0; a_req_addr = 0; a_req_wdata = 0; a_rsp_ready = 0;
    b_req_valid = 0; b_req_write = 0; b_req_addr = 0; b_req_wdata = 0; b_rsp_ready = 0;
    @(posedge clk); #2;
    checks++;
    if ({a_req_ready, a_rsp_valid, a_rsp_error, a_busy} !== 4'b0 || a_rsp_rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs: ready/valid/err/busy=%b rdata=%h, need 0000 and 0",
               {a_req_ready, a_rsp_valid, a_rsp_error, a_busy}, a_rsp_rdata);
    end
    @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    #1;
    checks++;
    if (a_req_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_ready: req_ready=%b before first edge, need 0", a_req_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (a_req_ready !== 1'b1 || b_req_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_release: a=%b b=%b, need 1 1", a_req_ready, b_req_ready);
    end
  endtask

  task automatic test_store_load();
    int lat; logic [31:0] rd; logic er; bit st, rl, io, to;
    run_txn(1'b1, 32'd5, 32'hDEADBEEF, 0, lat, rd, er, st, rl, io, to);
    model_a[32'd5] = 32'hDEADBEEF;
    checks++;
    if (to || lat != LAT_A) begin
      errors++;
      $display("FAIL store5_latency: cycles=%0d timeout=%b, need cycles=%0d", lat + 1, to, LAT_A + 1);
    end
    checks++;
    if (rd !== 32'h0 || er !== 1'b0) begin
      errors++;
      $display("FAIL store5_response: rdata=%h err=%b, need 0 and 0", rd, er);
    end
    checks++;
    if (!rl || !io) begin
      errors++;
      $display("FAIL store5_ready: ready_low=%b idle_after=%b, need 1 1", rl, io);
    end
    run_txn(1'b0, 32'd5, 32'h0, 0, lat, rd, er, st, rl, io, to);
    checks++;
    if (to || rd !== 32'hDEADBEEF || er !== 1'b0 || lat != LAT_A) begin
      errors++;
      $display("FAIL load5: rdata=%h err=%b cycles=%0d, need DEADBEEF 0 %0d", rd, er, lat + 1, LAT_A + 1);
    end
  endtask

  task automatic test_out_of_range();
    int lat; logic [31:0] rd, v; logic er; bit st, rl, io, to;
    v = $urandom;
    run_txn(1'b1, 32'd0, v, 0, lat, rd, er, st, rl, io, to);
    model_a[32'd0] = v;
    run_txn(1'b0, 32'd256, 32'h0, 0, lat, rd, er, st, rl, io, to);
    checks++;
    if (to || er !== 1'b1 || rd !== 32'h0) begin
      errors++;
      $display("FAIL load256: err=%b rdata=%h timeout=%b, need 1 0 0", er, rd, to);
    end
    run_txn(1'b1, 32'd256, ~v, 0, lat, rd, er, st, rl, io, to);
    checks++;
    if (to || er !== 1'b1 || rd !== 32'h0) begin
      errors++;
      $display("FAIL store256: err=%b rdata=%h, need 1 0", er, rd);
    end
    run_txn(1'b1, 32'h8000_0000, 32'h5A5A5A5A, 0, lat, rd, er, st, rl, io, to);
    checks++;
    if (to || er !== 1'b1) begin
      errors++;
      $display("FAIL store_high_addr: err=%b, need 1", er);
    end
    run_txn(1'b0, 32'd0, 32'h0, 0, lat, rd, er, st, rl, io, to);
    checks++;
    if (to || rd !== v || er !== 1'b0) begin
      errors++;
      $display("FAIL load0_unchanged: rdata=%h err=%b, need %h 0", rd, er, v);
    end
    run_txn(1'b1, 32'd255, 32'hCAFEF00D, 0, lat, rd, er, st, rl, io, to);
    model_a[32'd255] = 32'hCAFEF00D;
    run_txn(1'b0, 32'd255, 32'h0, 0, lat, rd, er, st, rl, io, to);
    checks++;
    if (to || rd !== 32'hCAFEF00D || er !== 1'b0) begin
      errors++;
      $display("FAIL load255: rdata=%h err=%b, need CAFEF00D 0", rd, er);
    end
  endtask

  task automatic test_hold();
    int lat; logic [31:0] rd; logic er; bit st, rl, io, to;
    run_txn(1'b0, 32'd5, 32'h0, 4, lat, rd, er, st, rl, io, to);
    checks++;
    if (to || !st || rd !== model_a[32'd5] || er !== 1'b0) begin
      errors++;
      $display("FAIL hold_stable: stable=%b rdata=%h err=%b, need 1 %h 0", st, rd, er, model_a[32'd5]);
    end
    checks++;
    if (!rl || !io) begin
      errors++;
      $display("FAIL hold_ready: ready_low=%b idle_after=%b, need 1 1", rl, io);
    end
  endtask

  task automatic test_random();
    int lat; logic [31:0] rd, addr, wd, exp_rd; logic er, wr, exp_er; bit st, rl, io, to;
    for (int n = 0; n < 30; n++) begin
      case ($urandom_range(0, 3))
        0, 1:    addr = 32'($urandom_range(0, 15));
        2:       addr = 32'($urandom_range(250, 255));
        default: begin
          case ($urandom_range(0, 2))
            0:       addr = 32'($urandom_range(256, 300));
            1:       addr = 32'h8000_0005;
            default: addr = 32'hFFFF_FFFF;
          endcase
        end
      endcase
      wr = 1'($urandom_range(0, 1));
      if (!wr && addr < DEPTH && !model_a.exists(addr)) wr = 1'b1;
      wd = $urandom;
      exp_er = (addr >= DEPTH);
      exp_rd = (!wr && !exp_er) ? model_a[addr] : 32'h0;
      run_txn(wr, addr, wd, $urandom_range(0, 3), lat, rd, er, st, rl, io, to);
      if (wr && !exp_er) model_a[addr] = wd;
      checks++;
      if (to || lat != LAT_A || rd !== exp_rd || er !== exp_er || !st || !rl || !io) begin
        errors++;
        $display("FAIL random_txn%0d addr=%h wr=%b: cycles=%0d rdata=%h err=%b stable=%b rl=%b idle=%b to=%b, need cycles=%0d rdata=%h err=%b and flags 1110",
                 n, addr, wr, lat + 1, rd, er, st, rl, io, to, LAT_A + 1, exp_rd, exp_er);
      end
    end
  endtask

  task automatic test_abort();
    int lat; logic [31:0] rd; logic er; bit st, rl, io, to;
    run_txn(1'b1, 32'd7, 32'hAAAA5555, 0, lat, rd, er, st, rl, io, to);
    model_a[32'd7] = 32'hAAAA5555;
    a_req_valid = 1'b1; a_req_write = 1'b1; a_req_addr = 32'd7; a_req_wdata = 32'h1234;
    @(posedge clk); #1;
    a_req_valid = 1'b0;
    checks++;
    if (a_busy !== 1'b1) begin
      errors++;
      $display("FAIL abort_accepted: busy=%b, need 1", a_busy);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({a_req_ready, a_rsp_valid, a_rsp_error, a_busy} !== 4'b0 || a_rsp_rdata !== 32'h0) begin
      errors++;
      $display("FAIL abort_outputs: ready/valid/err/busy=%b rdata=%h, need 0000 and 0",
               {a_req_ready, a_rsp_valid, a_rsp_error, a_busy}, a_rsp_rdata);
    end
    @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (a_rsp_valid !== 1'b0 || a_req_ready !== 1'b1) begin
      errors++;
      $display("FAIL abort_no_response: rsp_valid=%b req_ready=%b, need 0 1", a_rsp_valid, a_req_ready);
    end
    run_txn(1'b0, 32'd7, 32'h0, 0, lat, rd, er, st, rl, io, to);
    checks++;
    if (to || rd !== 32'hAAAA5555 || er !== 1'b0) begin
      errors++;
      $display("FAIL abort_load7: rdata=%h err=%b, need AAAA5555 0", rd, er);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] addr, wd, exp_rd; logic wr, exp_er, exp_valid; int responses;
    responses = 0;
    exp_rd = '0; exp_er = 1'b0;
    b_rsp_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (k % 2 == 0) begin
        addr = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(256, 270)) : 32'($urandom_range(0, 7));
        wr = 1'($urandom_range(0, 1));
        if (!wr && addr < DEPTH && !model_b.exists(addr)) wr = 1'b1;
        wd = $urandom;
        exp_er = (addr >= DEPTH);
        exp_rd = (!wr && !exp_er) ? model_b[addr] : 32'h0;
        if (wr && !exp_er) model_b[addr] = wd;
      end else begin
        addr = $urandom; wr = 1'($urandom_range(0, 1)); wd = $urandom;
      end
      b_req_valid = 1'b1; b_req_write = wr; b_req_addr = addr; b_req_wdata = wd;
      @(posedge clk); #1;
      exp_valid = (k % 2 == 0);
      if (b_rsp_valid === 1'b1) responses++;
      checks++;
      if (b_rsp_valid !== exp_valid) begin
        errors++;
        $display("FAIL b2b_valid_edge%0d: rsp_valid=%b, need %b", k, b_rsp_valid, exp_valid);
      end else if (exp_valid && (b_rsp_rdata !== exp_rd || b_rsp_error !== exp_er)) begin
        errors++;
        $display("FAIL b2b_data_edge%0d: rdata=%h err=%b, need %h %b", k, b_rsp_rdata, b_rsp_error, exp_rd, exp_er);
      end
    end
    b_req_valid = 1'b0;
    b_rsp_ready = 1'b0;
    checks++;
    if (responses != 10) begin
      errors++;
      $display("FAIL b2b_count: responses=%0d, need 10", responses);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, need completion", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_store_load();
    test_out_of_range();
    test_hold();
    test_random();
    test_abort();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 The parameter list SHALL be: DEPTH, 256, number of 32-bit words stored.
REQ-002 The parameter list SHALL be: LATENCY, 2, wait cycles before a response (legal 0..15).
REQ-003 The port list SHALL be: clk  input  1  single clock, all logic on rising edge.
REQ-004 The port list SHALL be: rst_n  input  1  reset, asynchronous and active-low.
REQ-005 The port list SHALL be: req_valid  input  1  initiator presents a request.
REQ-006 The port list SHALL be: req_ready  output  1  responder can accept a request.
REQ-007 The port list SHALL be: req_write  input  1  1 = store, 0 = load.
REQ-008 The port list SHALL be: req_addr  input  32  word address (not byte).
REQ-009 The port list SHALL be: req_wdata  input  32  store data.
REQ-010 The port list SHALL be: rsp_valid  output  1  response available.
REQ-011 The port list SHALL be: rsp_ready  input  1  initiator accepts response.
REQ-012 The port list SHALL be: rsp_rdata  output  32  load data; 0 for stores and errors.
REQ-013 The port list SHALL be: rsp_error  output  1  request address was out of range.
REQ-014 The port list SHALL be: busy  output  1  a request is outstanding (state not IDLE).

Function
REQ-015 The block SHALL implement the FSM states IDLE, WAIT and RESP; it accepts one request at a time and does not pipeline requests.
REQ-016 In IDLE, req_ready SHALL be 1. A request is accepted on a clock edge where req_valid=1. On acceptance, addr, write and wdata SHALL be captured in registers.
REQ-017 After acceptance with LATENCY=0, the FSM SHALL go to RESP. With LATENCY>0, it SHALL go to WAIT with the counter loaded to LATENCY-1.
REQ-018 In WAIT, the counter SHALL decrement each cycle. When the counter is 0, the FSM SHALL go to RESP on the next edge.
REQ-019 rsp_valid SHALL first assert exactly LATENCY+1 cycles after the acceptance edge.
REQ-020 The memory access SHALL be performed on the edge that enters RESP. A store writes the array; a load latches the read word into rsp_rdata.
REQ-021 If captured addr >= DEPTH, the array SHALL NOT be written, rsp_rdata SHALL be 0 and rsp_error SHALL be 1. Upper address bits SHALL NOT wrap or alias.
REQ-022 In RESP, rsp_valid SHALL be 1, and rsp_rdata and rsp_error SHALL hold stable until rsp_ready=1.
REQ-023 A handshake edge in RESP (rsp_valid=1 and rsp_ready=1) SHALL return the FSM to IDLE. No new request is accepted on that same edge.
REQ-024 req_ready SHALL be 0 in WAIT and RESP. Changes to the request inputs while busy SHALL be ignored.
REQ-025 A load following a store to the same address SHALL return the stored value.
REQ-026 Store responses SHALL carry rsp_rdata=0 and rsp_error=0, unless the address is out of range.

Reset
REQ-027 rst_n=0 SHALL asynchronously force state=IDLE, counter=0, rsp_valid=0, rsp_rdata=0, rsp_error=0, busy=0 and all captured request registers to 0.
REQ-028 While rst_n=0, req_ready SHALL be 0. It SHALL be 1 from the first clock edge after rst_n deasserts.
REQ-029 Reset asserted in WAIT or RESP SHALL abort the transaction. A store not yet committed SHALL NOT be written, and no response is produced.
REQ-030 Array contents SHALL NOT be cleared by reset.

Structure
REQ-031 The state enum (IDLE/WAIT/RESP) and the constant MEM_WORD_W=32 SHALL live in the shared package h2bp.
REQ-032 Storage SHALL be one sub-module, dmem_array, with a single synchronous write port and read port and no reset. The FSM, counter and response registers SHALL stay in dmem_responder.

Verification
REQ-033 The bench SHALL cover: LATENCY=2, store addr 5 data 0xDEADBEEF, rsp_ready=1 -> rsp_valid high 3 cycles after acceptance, rsp_error=0, rsp_rdata=0.
REQ-034 The bench SHALL cover: then load addr 5 -> rsp_rdata=0xDEADBEEF on rsp_valid, rsp_error=0.
REQ-035 The bench SHALL cover: load addr 256 with DEPTH=256 -> rsp_error=1, rsp_rdata=0; a following load of addr 0 returns the unchanged value.
REQ-036 The bench SHALL cover: rsp_ready held 0 for 4 cycles in RESP -> rsp_valid, rsp_rdata and rsp_error stable all 4 cycles; req_ready=0 throughout; IDLE one cycle after rsp_ready=1.
REQ-037 The bench SHALL cover: LATENCY=0, back-to-back req_valid=1 -> one response per 2 cycles with rsp_ready=1; rsp_valid 1 cycle after acceptance.
REQ-038 The bench SHALL cover: store addr 7 data 0x1234, then rst_n pulsed low during WAIT -> all outputs 0 immediately; a later load of addr 7 does not return 0x1234 (prior content preserved).
